// File: rtl/dot_matrix_scan.sv
// Row-multiplexed scan of two (column, row) points onto an 8x8 LED matrix,
// with a per-frame input snapshot and a slow step_tick for the upstream sequencer.
module dot_matrix_scan #(
   parameter int ROW_HOLD        = 4,
   parameter int FRAMES_PER_STEP = 2
) (
   input  logic       ck,
   input  logic       reset,
   input  logic [2:0] data1,
   input  logic [2:0] data2,
   input  logic [2:0] data3,
   input  logic [2:0] data4,
   output logic [7:0] row_sel,
   output logic [7:0] col_n,
   output logic       frame_done,
   output logic       step_tick
);

   localparam logic [7:0] P_LAST = 8'(ROW_HOLD - 1);
   localparam logic [7:0] F_LAST = 8'(FRAMES_PER_STEP - 1);

   logic [7:0] p;
   logic [2:0] r;
   logic [7:0] f;
   logic [2:0] snap1, snap2, snap3, snap4;
   logic [7:0] pattern;
   logic       p_wrap;
   logic       frame_start;
   logic       frame_end;

   assign p_wrap      = (p == P_LAST);
   assign frame_start = (p == 8'd0) && (r == 3'd0);
   assign frame_end   = p_wrap && (r == 3'd7);

   // Coincident points simply set the same bit twice.
   always_comb begin
      pattern = 8'h00;
      if (snap2 == r) pattern[snap1] = 1'b1;
      if (snap4 == r) pattern[snap3] = 1'b1;
   end

   always_ff @(posedge ck) begin
      if (reset) begin
         p          <= 8'd0;
         r          <= 3'd0;
         f          <= 8'd0;
         snap1      <= 3'd0;
         snap2      <= 3'd0;
         snap3      <= 3'd0;
         snap4      <= 3'd0;
         row_sel    <= 8'h00;
         col_n      <= 8'hFF;
         frame_done <= 1'b0;
         step_tick  <= 1'b0;
      end else begin
         p <= p_wrap ? 8'd0 : p + 8'd1;
         if (p_wrap) r <= r + 3'd1;

         if (frame_start) begin
            snap1 <= data1;
            snap2 <= data2;
            snap3 <= data3;
            snap4 <= data4;
         end

         // First cycle of each row is blanked so the previous row's columns never ghost.
         if (p == 8'd0) begin
            row_sel <= 8'h01 << r;
            col_n   <= 8'hFF;
         end else begin
            col_n <= ~pattern;
         end

         frame_done <= frame_end;
         step_tick  <= 1'b0;
         if (frame_end) begin
            if (f == F_LAST) begin
               f         <= 8'd0;
               step_tick <= 1'b1;
            end else begin
               f <= f + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Scoreboard bench for dot_matrix_scan: three instances (4/2, 4/1, 2/2) share stimulus;
// expected outputs are queued per edge and checked by a separate monitor.
module tb_dot_matrix_scan;

   logic       ck = 1'b0;
   logic       reset;
   logic [2:0] data1, data2, data3, data4;
   logic [7:0] rs [3];
   logic [7:0] cn [3];
   logic       fd [3];
   logic       st [3];

   always #5 ck = ~ck;

   dot_matrix_scan #(.ROW_HOLD(4), .FRAMES_PER_STEP(2)) u_d0 (
      .ck(ck), .reset(reset), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
      .row_sel(rs[0]), .col_n(cn[0]), .frame_done(fd[0]), .step_tick(st[0]));
   dot_matrix_scan #(.ROW_HOLD(4), .FRAMES_PER_STEP(1)) u_d1 (
      .ck(ck), .reset(reset), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
      .row_sel(rs[1]), .col_n(cn[1]), .frame_done(fd[1]), .step_tick(st[1]));
   dot_matrix_scan #(.ROW_HOLD(2), .FRAMES_PER_STEP(2)) u_d2 (
      .ck(ck), .reset(reset), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
      .row_sel(rs[2]), .col_n(cn[2]), .frame_done(fd[2]), .step_tick(st[2]));

   typedef struct {
      int         cyc;
      int         d;
      logic [7:0] rs;
      logic [7:0] cn;
      logic       fd;
      logic       st;
   } exp_t;

   exp_t       q [$];
   exp_t       mx;
   int         edge_cnt = 0;
   int         n_chk    = 0;
   int         n_fail   = 0;
   int         e        = 0;
   int         rh_a  [3] = '{4, 4, 2};
   int         fps_a [3] = '{2, 1, 2};
   logic [7:0] tbl [8];
   logic [7:0] cur_tbl [3][8];

   always @(posedge ck) edge_cnt++;

   task automatic chk(input string nm, input int d, input int cyc,
                      input logic [7:0] act, input logic [7:0] ex);
      n_chk++;
      if (act !== ex) begin
         n_fail++;
         $display("FAIL %s dut%0d edge %0d: got %h, expected %h", nm, d, cyc, act, ex);
      end
   endtask

   always @(negedge ck) begin
      while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
         mx = q.pop_front();
         chk("edge_align", mx.d, edge_cnt, 8'(mx.cyc), 8'(edge_cnt));
         chk("row_sel",    mx.d, mx.cyc, rs[mx.d], mx.rs);
         chk("col_n",      mx.d, mx.cyc, cn[mx.d], mx.cn);
         chk("frame_done", mx.d, mx.cyc, {7'd0, fd[mx.d]}, {7'd0, mx.fd});
         chk("step_tick",  mx.d, mx.cyc, {7'd0, st[mx.d]}, {7'd0, mx.st});
      end
   end

   // Queue the expected outputs of the coming edge, then take it. e is that edge's
   // index since reset release.
   task automatic step(input logic rst);
      exp_t x;
      int   rh, fl, rr, pp;
      reset = rst;
      for (int d = 0; d < 3; d++) begin
         x.cyc = edge_cnt + 1;
         x.d   = d;
         if (rst) begin
            x.rs = 8'h00;
            x.cn = 8'hFF;
            x.fd = 1'b0;
            x.st = 1'b0;
         end else begin
            rh = rh_a[d];
            fl = 8 * rh;
            rr = (e / rh) % 8;
            pp = e % rh;
            if (e % fl == 0)
               for (int k = 0; k < 8; k++) cur_tbl[d][k] = tbl[k];
            x.rs = 8'(1 << rr);
            x.cn = (pp == 0) ? 8'hFF : cur_tbl[d][rr];
            x.fd = (e % fl == fl - 1);
            x.st = (e % (fl * fps_a[d]) == fl * fps_a[d] - 1);
         end
         q.push_back(x);
      end
      @(posedge ck);
      #1;
      e = rst ? 0 : e + 1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic run_until(input int md, input int val);
      int guard;
      guard = 0;
      while (e % md != val && guard < 1000) begin
         step(1'b0);
         guard++;
      end
   endtask

   // Point A = (c1, r1), point B = (c2, r2); caller fills in the hand-computed rows.
   task automatic set_in(input logic [2:0] c1, input logic [2:0] r1,
                         input logic [2:0] c2, input logic [2:0] r2);
      data1 = c1;
      data2 = r1;
      data3 = c2;
      data4 = r2;
      for (int k = 0; k < 8; k++) tbl[k] = 8'hFF;
   endtask

   initial begin
      reset = 1'b1;
      set_in(3'd0, 3'd0, 3'd0, 3'd0);
      repeat (3) step(1'b1);

      set_in(3'd0, 3'd6, 3'd6, 3'd3);
      tbl[6] = 8'hFE;
      tbl[3] = 8'hBF;
      run(64);

      run(20);
      step(1'b1);
      run(32);

      set_in(3'd2, 3'd5, 3'd2, 3'd5);
      tbl[5] = 8'hFB;
      run(64);

      set_in(3'd1, 3'd4, 3'd7, 3'd4);
      tbl[4] = 8'h7D;
      run(64);

      set_in(3'd0, 3'd0, 3'd7, 3'd7);
      tbl[0] = 8'hFE;
      tbl[7] = 8'h7F;
      run_until(32, 0);
      run(9);
      set_in(3'd3, 3'd0, 3'd7, 3'd7);
      tbl[0] = 8'hF7;
      tbl[7] = 8'h7F;
      run(64);

      run_until(32, 0);
      step(1'b0);
      set_in(3'd5, 3'd0, 3'd7, 3'd7);
      tbl[0] = 8'hDF;
      tbl[7] = 8'h7F;
      run(64);

      @(negedge ck);
      #1;
      chk("queue_drained", 0, edge_cnt, 8'(q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
